// File: rtl/segment_counter_mux.sv
// BCD up/down counter with load, wrap pulse and a time-multiplexed
// active-low 7-segment scanner driving one digit at a time.
module segment_counter_mux #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            segment,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  wrap
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

  logic [TW-1:0]          tick_q, tick_d;
  logic [SW-1:0]          scan_q, scan_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic                   wrap_q, wrap_d;
  logic [6:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      sel_q, sel_d;
  logic                   step;

  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Load clears the divider and suppresses the step due this cycle.
  always_comb begin
    step   = 1'b0;
    tick_d = tick_q;
    if (load) begin
      tick_d = '0;
    end else if (en) begin
      if (tick_q == TICK_MAX) begin
        tick_d = '0;
        step   = 1'b1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  // Ripple the carry/borrow through all digits in one cycle; a carry
  // surviving past the top digit is the full-range roll-over.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    carry  = 1'b0;
    dig    = '0;
    if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig = load_value[4*i +: 4];
        bcd_d[4*i +: 4] = (dig > 4'd9) ? 4'd0 : dig;
      end
    end else if (step) begin
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        dig = bcd_q[4*i +: 4];
        if (carry) begin
          if (up_down) begin
            if (dig == 4'd9) begin
              bcd_d[4*i +: 4] = 4'd0;
            end else begin
              bcd_d[4*i +: 4] = dig + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (dig == 4'd0) begin
              bcd_d[4*i +: 4] = 4'd9;
            end else begin
              bcd_d[4*i +: 4] = dig - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
      wrap_d = carry;
    end
  end

  always_comb begin
    scan_d = scan_q;
    idx_d  = idx_q;
    if (scan_q == SCAN_MAX) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end else begin
      scan_d = scan_q + SW'(1);
    end
  end

  // Select and pattern come from the same index and bcd snapshot.
  always_comb begin
    logic [3:0] cur;
    cur   = '0;
    sel_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        sel_d[i] = 1'b0;
        cur      = bcd_q[4*i +: 4];
      end
    end
    seg_d = seg_enc(cur);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      scan_q <= '0;
      idx_q  <= '0;
      bcd_q  <= '0;
      wrap_q <= 1'b0;
      seg_q  <= 7'b1111111;
      sel_q  <= ~DIGITS'(1);
    end else begin
      tick_q <= tick_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
      seg_q  <= seg_d;
      sel_q  <= sel_d;
    end
  end

  assign bcd       = bcd_q;
  assign wrap      = wrap_q;
  assign segment   = seg_q;
  assign digit_sel = sel_q;

endmodule

// File: tb/tb_segment_counter_mux.sv
// Scoreboard bench for segment_counter_mux: directed scenarios plus
// random traffic checked against an integer-valued reference model.
module tb_segment_counter_mux;

  localparam int D  = 2;
  localparam int TD = 4;
  localparam int SD = 2;

  logic       clk = 1'b0;
  logic       rst, en, up_down, load;
  logic [7:0] load_value;
  logic [7:0] bcd;
  logic [6:0] segment;
  logic [1:0] digit_sel;
  logic       wrap;

  segment_counter_mux #(
    .DIGITS(D), .TICK_DIV(TD), .SCAN_DIV(SD)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down),
    .load(load), .load_value(load_value),
    .bcd(bcd), .segment(segment),
    .digit_sel(digit_sel), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] bcd;
    logic       wrap;
    logic [6:0] seg;
    logic [1:0] sel;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  int         m_cnt, m_tick, m_scan, m_idx;
  logic       m_wrap;
  logic [6:0] m_seg;
  logic [1:0] m_sel;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int clamp(input logic [3:0] n);
    return (n > 4'd9) ? 0 : int'(n);
  endfunction

  task automatic cmp(input string name, input logic [7:0] got,
                     input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  // One clock of stimulus; model predicts outputs after the next edge.
  task automatic cyc(input logic r, input logic e, input logic u,
                     input logic l, input logic [7:0] lv);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; up_down = u; load = l; load_value = lv;
    if (r) begin
      m_cnt = 0; m_tick = 0; m_scan = 0; m_idx = 0;
      m_wrap = 1'b0; m_seg = 7'b1111111; m_sel = 2'b10;
    end else begin
      m_seg  = seg_of(m_idx == 0 ? m_cnt % 10 : m_cnt / 10);
      m_sel  = (m_idx == 0) ? 2'b10 : 2'b01;
      m_wrap = 1'b0;
      if (m_scan == SD - 1) begin
        m_scan = 0;
        m_idx  = (m_idx + 1) % D;
      end else begin
        m_scan++;
      end
      if (l) begin
        m_cnt  = clamp(lv[7:4]) * 10 + clamp(lv[3:0]);
        m_tick = 0;
      end else if (e) begin
        if (m_tick == TD - 1) begin
          m_tick = 0;
          if (u) begin
            m_wrap = (m_cnt == 99);
            m_cnt  = (m_cnt + 1) % 100;
          end else begin
            m_wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + 99) % 100;
          end
        end else begin
          m_tick++;
        end
      end
    end
    x.bcd  = {4'(m_cnt / 10), 4'(m_cnt % 10)};
    x.wrap = m_wrap;
    x.seg  = m_seg;
    x.sel  = m_sel;
    q.push_back(x);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("bcd", bcd, e.bcd);
      cmp("wrap", {7'd0, wrap}, {7'd0, e.wrap});
      cmp("segment", {1'b0, segment}, {1'b0, e.seg});
      cmp("digit_sel", {6'd0, digit_sel}, {6'd0, e.sel});
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; up_down = 1'b1; load = 1'b0;
    load_value = '0;
    m_cnt = 0; m_tick = 0; m_scan = 0; m_idx = 0;
    m_wrap = 1'b0; m_seg = 7'b1111111; m_sel = 2'b10;

    repeat (2) cyc(1, 0, 1, 0, 8'h00);

    repeat (40) cyc(0, 1, 1, 0, 8'h00);
    settle();
    cmp("up40_bcd", bcd, 8'h10);

    cyc(0, 0, 1, 1, 8'h99);
    repeat (4) cyc(0, 1, 1, 0, 8'h00);
    settle();
    cmp("upwrap_bcd", bcd, 8'h00);
    cmp("upwrap_pulse", {7'd0, wrap}, 8'd1);
    cyc(0, 0, 1, 0, 8'h00);
    settle();
    cmp("upwrap_once", {7'd0, wrap}, 8'd0);

    cyc(0, 1, 0, 1, 8'h00);
    repeat (4) cyc(0, 1, 0, 0, 8'h00);
    settle();
    cmp("dnwrap_bcd", bcd, 8'h99);
    cmp("dnwrap_pulse", {7'd0, wrap}, 8'd1);
    repeat (4) cyc(0, 1, 0, 0, 8'h00);
    settle();
    cmp("dn98_bcd", bcd, 8'h98);
    cmp("dn98_wrap", {7'd0, wrap}, 8'd0);

    cyc(0, 0, 1, 1, 8'h00);
    repeat (3) cyc(0, 1, 1, 0, 8'h00);
    cyc(0, 1, 1, 1, 8'hA3);
    settle();
    cmp("loadprio_bcd", bcd, 8'h03);
    cmp("loadprio_wrap", {7'd0, wrap}, 8'd0);
    repeat (3) cyc(0, 1, 1, 0, 8'h00);
    settle();
    cmp("nostep_early", bcd, 8'h03);
    cyc(0, 1, 1, 0, 8'h00);
    settle();
    cmp("step_after4", bcd, 8'h04);

    cyc(0, 0, 1, 1, 8'h47);
    repeat (8) cyc(0, 0, 1, 0, 8'h00);

    cyc(0, 0, 1, 1, 8'h58);
    repeat (3) cyc(0, 1, 1, 0, 8'h00);
    cyc(1, 1, 1, 0, 8'h00);
    settle();
    cmp("rst_bcd", bcd, 8'h00);
    cmp("rst_seg", {1'b0, segment}, 8'h7F);
    cmp("rst_sel", {6'd0, digit_sel}, 8'h02);
    cyc(0, 0, 1, 0, 8'h00);
    settle();
    cmp("post_rst_seg", {1'b0, segment}, 8'h01);

    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(3) != 0),
          1'($urandom), ($urandom_range(15) == 0), 8'($urandom));
    end

    repeat (2) @(posedge clk);
    #2;
    cmp("queue_drained", 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
